// File: rtl/sdio_clk_ctrl.sv
// ----------------------------------------------------------------------------
// sdio_clk_ctrl
//   Sequencer/configurator for the SD card clock generator. Runs the power-up
//   sequence of INIT_CYCLES card-clock rising edges, performs glitch-free
//   divider changes (stop, reload, restart) and pauses the card clock for data
//   flow control. Every output is a register.
//
//   Optional feature: define SDIO_CLK_AUTO_GATE_EN to park the card clock
//   after IDLE_GAP rising edges with no command/data activity.
//
// Ports
//   sd_clk, sd_rst          system clock, synchronous active-high reset
//   clk_en_req              host request: card clock on
//   div_req, div_update     requested divider, one-cycle apply pulse
//   cmd_busy, data_busy     command / data engine activity
//   dir_tx, tx_empty,
//   rx_full                 flow-control inputs from the data engine
//   clk_o, clk_oe,
//   rx_en, tx_en            observed generator state and edge strobes
//   sd_clk_en, sd_clk_div,
//   sd_clk_pause            generator controls
//   clk_ready, busy,
//   upd_done                status to the host
// ----------------------------------------------------------------------------
module sdio_clk_ctrl #(
    parameter int         INIT_CYCLES = 74,
    parameter logic [7:0] INIT_DIV    = 8'd124
`ifdef SDIO_CLK_AUTO_GATE_EN
    ,
    parameter int         IDLE_GAP    = 16
`endif
) (
    input  logic       sd_clk,
    input  logic       sd_rst,
    input  logic       clk_en_req,
    input  logic [7:0] div_req,
    input  logic       div_update,
    input  logic       cmd_busy,
    input  logic       data_busy,
    input  logic       dir_tx,
    input  logic       tx_empty,
    input  logic       rx_full,
    input  logic       clk_o,
    input  logic       clk_oe,
    input  logic       rx_en,
    input  logic       tx_en,
    output logic       sd_clk_en,
    output logic [7:0] sd_clk_div,
    output logic       sd_clk_pause,
    output logic       clk_ready,
    output logic       busy,
    output logic       upd_done
);

    localparam int CW = $clog2(INIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_OFF, S_START, S_RUN, S_STOP, S_UPDATE
    } state_t;

    state_t          r_state, w_state_nxt;
    state_t          r_target, w_target_nxt;
    logic            r_en, w_en_nxt;
    logic [7:0]      r_div, w_div_nxt;
    logic            r_pause, w_pause_nxt;
    logic            r_ready, w_ready_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_upd, w_upd_nxt;
    logic            r_pend, w_pend_nxt;
    logic [7:0]      r_pend_div, w_pend_div_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_pause_req;
    logic            w_flow_nxt;
    logic            w_auto_nxt;

    // The falling-edge strobe carries no information this controller needs.
    logic            w_unused_tx_en;
    assign w_unused_tx_en = tx_en;

    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_pause_req = data_busy & ~cmd_busy & (dir_tx ? tx_empty : rx_full);
    // Only enter pause while the card clock is low so it always parks low;
    // once paused, hold until the request drops.
    assign w_flow_nxt  = w_pause_req & (r_pause | ~clk_o);

`ifdef SDIO_CLK_AUTO_GATE_EN
    localparam int IW = $clog2(IDLE_GAP + 1);

    logic [IW-1:0] r_idle, w_idle_nxt;
    logic          r_auto;

    always_comb begin
        w_idle_nxt = r_idle;
        w_auto_nxt = r_auto;
        if (r_state != S_RUN || cmd_busy || data_busy) begin
            w_idle_nxt = '0;
            w_auto_nxt = 1'b0;
        end else begin
            if (rx_en && r_idle != IW'(IDLE_GAP))
                w_idle_nxt = r_idle + IW'(1);
            if (r_idle == IW'(IDLE_GAP) && !clk_o)
                w_auto_nxt = 1'b1;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (sd_rst) begin
            r_idle <= '0;
            r_auto <= 1'b0;
        end else begin
            r_idle <= w_idle_nxt;
            r_auto <= w_auto_nxt;
        end
    end
`else
    assign w_auto_nxt = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_en_nxt       = r_en;
        w_div_nxt      = r_div;
        w_pause_nxt    = 1'b0;
        w_ready_nxt    = r_ready;
        w_busy_nxt     = r_busy;
        w_upd_nxt      = 1'b0;
        w_pend_nxt     = r_pend;
        w_pend_div_nxt = r_pend_div;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_OFF: begin
                w_en_nxt    = 1'b0;
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                // A fresh request supersedes a divider left pending by STOP.
                if (div_update) begin
                    w_div_nxt  = div_req;
                    w_upd_nxt  = 1'b1;
                    w_pend_nxt = 1'b0;
                end else if (r_pend) begin
                    w_div_nxt  = r_pend_div;
                    w_upd_nxt  = 1'b1;
                    w_pend_nxt = 1'b0;
                end
                if (clk_en_req) begin
                    w_state_nxt = S_START;
                    w_en_nxt    = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end

            S_START: begin
                if (div_update) begin
                    w_pend_div_nxt = div_req;
                    w_pend_nxt     = 1'b1;
                end
                if (!clk_en_req) begin
                    w_state_nxt  = S_STOP;
                    w_target_nxt = S_OFF;
                    w_en_nxt     = 1'b0;
                    w_ready_nxt  = 1'b0;
                    w_busy_nxt   = 1'b1;
                end else if (rx_en) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CW'(INIT_CYCLES)) begin
                        w_state_nxt = S_RUN;
                        w_ready_nxt = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
            end

            S_RUN: begin
                if (!clk_en_req) begin
                    w_state_nxt  = S_STOP;
                    w_target_nxt = S_OFF;
                    w_en_nxt     = 1'b0;
                    w_ready_nxt  = 1'b0;
                    w_busy_nxt   = 1'b1;
                    // Left pending; OFF applies it once the clock is down.
                    if (div_update) begin
                        w_pend_div_nxt = div_req;
                        w_pend_nxt     = 1'b1;
                    end
                end else if (div_update || r_pend) begin
                    if (div_update)
                        w_pend_div_nxt = div_req;
                    w_pend_nxt   = 1'b0;
                    w_state_nxt  = S_STOP;
                    w_target_nxt = S_UPDATE;
                    w_en_nxt     = 1'b0;
                    w_ready_nxt  = 1'b0;
                    w_busy_nxt   = 1'b1;
                end else begin
                    w_pause_nxt = w_flow_nxt | w_auto_nxt;
                end
            end

            S_STOP: begin
                if (div_update) begin
                    w_pend_div_nxt = div_req;
                    w_pend_nxt     = 1'b1;
                end
                // Generator finishes its high phase before dropping clk_oe;
                // reloading the divider before then could glitch the card.
                if (!clk_oe) begin
                    w_state_nxt = r_target;
                    if (r_target == S_OFF)
                        w_busy_nxt = 1'b0;
                end
            end

            S_UPDATE: begin
                w_div_nxt  = r_pend_div;
                w_upd_nxt  = 1'b1;
                w_pend_nxt = 1'b0;
                if (div_update) begin
                    w_pend_div_nxt = div_req;
                    w_pend_nxt     = 1'b1;
                end
                w_busy_nxt = 1'b0;
                if (clk_en_req) begin
                    w_state_nxt = S_RUN;
                    w_en_nxt    = 1'b1;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_OFF;
                    w_en_nxt    = 1'b0;
                    w_ready_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = S_OFF;
                w_en_nxt    = 1'b0;
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (sd_rst) begin
            r_state    <= S_OFF;
            r_target   <= S_OFF;
            r_en       <= 1'b0;
            r_div      <= INIT_DIV;
            r_pause    <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_upd      <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_div <= INIT_DIV;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_en       <= w_en_nxt;
            r_div      <= w_div_nxt;
            r_pause    <= w_pause_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_upd      <= w_upd_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign sd_clk_en    = r_en;
    assign sd_clk_div   = r_div;
    assign sd_clk_pause = r_pause;
    assign clk_ready    = r_ready;
    assign busy         = r_busy;
    assign upd_done     = r_upd;

endmodule

// File: tb/tb_sdio_clk_ctrl.sv
module tb_sdio_clk_ctrl;

    logic       sd_clk = 1'b0;
    logic       sd_rst = 1'b1;
    logic       clk_en_req = 1'b0;
    logic [7:0] div_req = 8'h00;
    logic       div_update = 1'b0;
    logic       cmd_busy = 1'b0;
    logic       data_busy = 1'b0;
    logic       dir_tx = 1'b0;
    logic       tx_empty = 1'b0;
    logic       rx_full = 1'b0;
    logic       clk_o = 1'b0;
    logic       clk_oe = 1'b0;
    logic       rx_en = 1'b0;
    logic       tx_en = 1'b0;
    logic       sd_clk_en;
    logic [7:0] sd_clk_div;
    logic       sd_clk_pause;
    logic       clk_ready;
    logic       busy;
    logic       upd_done;

    sdio_clk_ctrl #(.INIT_CYCLES(74), .INIT_DIV(8'd2)) dut (
        .sd_clk(sd_clk), .sd_rst(sd_rst), .clk_en_req(clk_en_req),
        .div_req(div_req), .div_update(div_update), .cmd_busy(cmd_busy),
        .data_busy(data_busy), .dir_tx(dir_tx), .tx_empty(tx_empty),
        .rx_full(rx_full), .clk_o(clk_o), .clk_oe(clk_oe), .rx_en(rx_en),
        .tx_en(tx_en), .sd_clk_en(sd_clk_en), .sd_clk_div(sd_clk_div),
        .sd_clk_pause(sd_clk_pause), .clk_ready(clk_ready), .busy(busy),
        .upd_done(upd_done)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct {
        string       nm;
        logic [12:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    function automatic logic [12:0] D(input logic en, input logic [7:0] dv,
                                      input logic pz, input logic rd,
                                      input logic bs, input logic up);
        return {en, dv, pz, rd, bs, up};
    endfunction

    task automatic tick(input string nm, input logic [12:0] exp);
        sb_t e;
        e.nm  = nm;
        e.exp = exp;
        sb.push_back(e);
        @(negedge sd_clk);
    endtask

    task automatic init_seq(input logic [7:0] dv);
        clk_en_req = 1'b1;
        rx_en      = 1'b0;
        tick("start_en", D(1, dv, 0, 0, 1, 0));
        clk_oe = 1'b1;
        for (int i = 1; i <= 74; i++) begin
            rx_en = 1'b1; clk_o = 1'b1;
            tick((i == 74) ? "init_ready" : "init_count",
                 (i == 74) ? D(1, dv, 0, 1, 0, 0) : D(1, dv, 0, 0, 1, 0));
            rx_en = 1'b0; clk_o = 1'b0;
            tick("init_hold",
                 (i == 74) ? D(1, dv, 0, 1, 0, 0) : D(1, dv, 0, 0, 1, 0));
        end
    endtask

    sb_t         mon_e;
    logic [12:0] mon_act;
    initial begin
        forever begin
            @(posedge sd_clk);
            #1;
            if (sb.size() > 0) begin
                mon_e   = sb.pop_front();
                mon_act = {sd_clk_en, sd_clk_div, sd_clk_pause, clk_ready, busy, upd_done};
                n_chk++;
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got en=%b div=%h pause=%b ready=%b busy=%b upd=%b, expected en=%b div=%h pause=%b ready=%b busy=%b upd=%b",
                             mon_e.nm, $time,
                             mon_act[12], mon_act[11:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                             mon_e.exp[12], mon_e.exp[11:4], mon_e.exp[3], mon_e.exp[2], mon_e.exp[1], mon_e.exp[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick("reset", D(0, 8'd2, 0, 0, 0, 0));
        sd_rst = 1'b0;

        init_seq(8'd2);
        n_chk++;
        if (clk_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_init_ready @%0t: ready=%b busy=%b", $time, clk_ready, busy);
        end

        div_req = 8'h00; div_update = 1'b1;
        tick("div_stop", D(0, 8'd2, 0, 0, 1, 0));
        div_update = 1'b0;
        tick("stop_wait", D(0, 8'd2, 0, 0, 1, 0));
        tick("stop_wait", D(0, 8'd2, 0, 0, 1, 0));
        clk_oe = 1'b0;
        tick("stop_exit", D(0, 8'd2, 0, 0, 1, 0));
        tick("upd_apply", D(1, 8'h00, 0, 1, 0, 1));
        clk_oe = 1'b1;
        tick("upd_once", D(1, 8'h00, 0, 1, 0, 0));

        data_busy = 1'b1; dir_tx = 1'b0; rx_full = 1'b1; clk_o = 1'b1;
        tick("pause_wait_hi", D(1, 8'h00, 0, 1, 0, 0));
        tick("pause_wait_hi", D(1, 8'h00, 0, 1, 0, 0));
        clk_o = 1'b0;
        tick("pause_set_lo", D(1, 8'h00, 1, 1, 0, 0));
        clk_o = 1'b1;
        tick("pause_hold", D(1, 8'h00, 1, 1, 0, 0));
        rx_full = 1'b0;
        tick("pause_clr", D(1, 8'h00, 0, 1, 0, 0));
        cmd_busy = 1'b1; rx_full = 1'b1; clk_o = 1'b0;
        tick("pause_cmd_block", D(1, 8'h00, 0, 1, 0, 0));
        tick("pause_cmd_block", D(1, 8'h00, 0, 1, 0, 0));
        cmd_busy = 1'b0; rx_full = 1'b0; dir_tx = 1'b1; tx_empty = 1'b1;
        tick("pause_tx", D(1, 8'h00, 1, 1, 0, 0));
        data_busy = 1'b0;
        tick("pause_tx_clr", D(1, 8'h00, 0, 1, 0, 0));
        dir_tx = 1'b0; tx_empty = 1'b0;

        clk_en_req = 1'b0; div_req = 8'h05; div_update = 1'b1;
        tick("off_stop", D(0, 8'h00, 0, 0, 1, 0));
        div_update = 1'b0;
        tick("off_stop_wait", D(0, 8'h00, 0, 0, 1, 0));
        clk_oe = 1'b0;
        tick("stop_to_off", D(0, 8'h00, 0, 0, 0, 0));
        tick("off_pend_apply", D(0, 8'h05, 0, 0, 0, 1));
        tick("off_idle", D(0, 8'h05, 0, 0, 0, 0));
        n_chk++;
        if (sd_clk_div !== 8'h05 || clk_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_off_div @%0t: div=%h ready=%b", $time, sd_clk_div, clk_ready);
        end

        clk_en_req = 1'b1;
        tick("restart", D(1, 8'h05, 0, 0, 1, 0));
        clk_oe = 1'b1; clk_en_req = 1'b0; div_req = 8'h33; div_update = 1'b1;
        tick("start_abort", D(0, 8'h05, 0, 0, 1, 0));
        div_update = 1'b0;
        tick("stop_hold", D(0, 8'h05, 0, 0, 1, 0));
        sd_rst = 1'b1;
        tick("rst_in_stop", D(0, 8'd2, 0, 0, 0, 0));
        sd_rst = 1'b0; clk_oe = 1'b0;
        tick("pend_cleared", D(0, 8'd2, 0, 0, 0, 0));
        tick("pend_cleared", D(0, 8'd2, 0, 0, 0, 0));
        n_chk++;
        if (sd_clk_div !== 8'd2 || upd_done !== 1'b0 || sd_clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_rst_pend @%0t: div=%h upd=%b en=%b", $time, sd_clk_div, upd_done, sd_clk_en);
        end

        div_req = 8'h10; div_update = 1'b1;
        tick("off_div", D(0, 8'h10, 0, 0, 0, 1));
        div_update = 1'b0;
        tick("off_div_once", D(0, 8'h10, 0, 0, 0, 0));

`ifdef SDIO_CLK_AUTO_GATE_EN
        init_seq(8'h10);
        for (int k = 1; k <= 16; k++) begin
            rx_en = 1'b1; clk_o = 1'b1;
            tick("auto_count", D(1, 8'h10, 0, 1, 0, 0));
            rx_en = 1'b0; clk_o = 1'b0;
            tick("auto_gate", D(1, 8'h10, (k == 16), 1, 0, 0));
        end
        cmd_busy = 1'b1;
        tick("auto_release", D(1, 8'h10, 0, 1, 0, 0));
        cmd_busy = 1'b0;
        tick("auto_rearm", D(1, 8'h10, 0, 1, 0, 0));
`endif

        @(posedge sd_clk);
        #2;
        if (n_chk < 12) begin
            n_fail++;
            $display("FAIL too few checks: %0d", n_chk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
